udp_tx_arbiter: RTL and testbench

- Shares the single UDP transmit channel of the network stack between three packet sources:
  - source 0: discovery reply
  - source 1: IQ/audio frames
  - source 2: wideband spectrum
- Sits between the packet builders and the network transmit interface in the tx_clock domain.
- Sequences request, start and byte transfer for each packet, and enforces the inter-packet gap.
- Detects stalled or short transfers and reports them to the source.

---
 rtl/udp_tx_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares the single UDP transmit channel between three sources.
// Discovery has absolute priority; IQ and spectrum alternate round-robin.
module udp_tx_arbiter #(
  parameter int MAX_LEN    = 1444,
  parameter int TIMEOUT    = 4095,
  parameter int GAP_CYCLES = 12
) (
  input  logic        tx_clock,
  input  logic        rst_n,
  input  logic        inhibit,
  input  logic [2:0]  src_req,
  input  logic [32:0] src_len,
  input  logic [23:0] src_data,
  output logic [2:0]  src_rdreq,
  output logic [2:0]  src_done,
  output logic [2:0]  src_err,
  output logic [2:0]  src_reject,
  output logic        udp_tx_request,
  output logic [10:0] udp_tx_length,
  output logic [7:0]  udp_tx_data,
  input  logic        udp_tx_enable,
  input  logic        udp_tx_active,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [10:0]   LMAX     = 11'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SEND,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [2:0]    r_grant;
  logic [10:0]   r_len;
  logic          r_req;
  logic [2:0]    r_done;
  logic [2:0]    r_err;
  logic [2:0]    r_rej;
  logic [15:0]   r_pkt;
  logic [7:0]    r_errc;
  logic          r_last_rr;
  logic [TW-1:0] r_to;
  logic [10:0]   r_cnt;
  logic          r_seen;
  logic          r_ovf;
  logic [GW-1:0] r_gap;

  logic [10:0] w_len [3];
  logic [2:0]  w_legal;
  logic [2:0]  w_bad;
  logic [2:0]  w_elig;
  logic [2:0]  w_win;
  logic [10:0] w_win_len;
  logic [7:0]  w_gdata;
  logic [7:0]  w_errc_inc;
  logic        w_room;
  logic        w_tmo;
  logic        w_rd;
  logic        w_end;
  logic        w_ok;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_len[i]   = src_len[11*i +: 11];
      w_legal[i] = src_req[i] && (w_len[i] != 11'd0)
                   && (w_len[i] <= LMAX);
    end
  end

  assign w_bad  = src_req & ~w_legal;
  assign w_elig = w_legal & {~inhibit, ~inhibit, 1'b1};

  // r_last_rr = 1 means source 1 went last, so source 2 wins a tie
  always_comb begin
    w_win = 3'b000;
    if (w_elig[0])
      w_win = 3'b001;
    else if (w_elig[1] && w_elig[2])
      w_win = r_last_rr ? 3'b100 : 3'b010;
    else if (w_elig[1])
      w_win = 3'b010;
    else if (w_elig[2])
      w_win = 3'b100;
  end

  always_comb begin
    w_win_len = 11'd0;
    unique case (1'b1)
      w_win[0]: w_win_len = w_len[0];
      w_win[1]: w_win_len = w_len[1];
      w_win[2]: w_win_len = w_len[2];
      default:  w_win_len = 11'd0;
    endcase
  end

  always_comb begin
    w_gdata = 8'h00;
    unique case (1'b1)
      r_grant[0]: w_gdata = src_data[7:0];
      r_grant[1]: w_gdata = src_data[15:8];
      r_grant[2]: w_gdata = src_data[23:16];
      default:    w_gdata = 8'h00;
    endcase
  end

  assign w_room = (r_cnt != r_len);
  assign w_tmo  = (r_to == TO_LAST);
  assign w_rd   = (r_state == S_SEND) && udp_tx_active && w_room;
  assign w_end  = ((r_state == S_REQ) && !udp_tx_enable && w_tmo)
               || ((r_state == S_SEND) && !udp_tx_active
                   && (r_seen || w_tmo));
  assign w_ok   = (r_state == S_SEND) && !udp_tx_active && r_seen
               && !r_ovf && !w_room;
  assign w_errc_inc = (r_errc == 8'hFF) ? r_errc : r_errc + 8'd1;

  always_ff @(posedge tx_clock) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= 3'b000;
      r_len     <= 11'd0;
      r_req     <= 1'b0;
      r_done    <= 3'b000;
      r_err     <= 3'b000;
      r_rej     <= 3'b000;
      r_pkt     <= 16'd0;
      r_errc    <= 8'd0;
      r_last_rr <= 1'b1;
      r_to      <= '0;
      r_cnt     <= 11'd0;
      r_seen    <= 1'b0;
      r_ovf     <= 1'b0;
      r_gap     <= '0;
    end else begin
      r_done <= 3'b000;
      r_err  <= 3'b000;
      r_rej  <= 3'b000;
      unique case (r_state)
        S_IDLE: begin
          r_rej <= w_bad;
          if (|w_bad)
            r_errc <= w_errc_inc;
          if (|w_win) begin
            r_grant <= w_win;
            r_len   <= w_win_len;
            r_req   <= 1'b1;
            r_to    <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (udp_tx_enable) begin
            r_req   <= 1'b0;
            r_cnt   <= 11'd0;
            r_seen  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_SEND;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_SEND: begin
          if (udp_tx_active) begin
            r_seen <= 1'b1;
            // past the latched length: stop reading, flag the overrun
            if (w_room)
              r_cnt <= r_cnt + 11'd1;
            else
              r_ovf <= 1'b1;
          end else if (!r_seen) begin
            r_to <= r_to + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST)
            r_state <= S_IDLE;
          else
            r_gap <= r_gap + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_end) begin
        r_state <= S_GAP;
        r_gap   <= '0;
        r_grant <= 3'b000;
        r_req   <= 1'b0;
        if (r_grant[1])
          r_last_rr <= 1'b1;
        else if (r_grant[2])
          r_last_rr <= 1'b0;
        if (w_ok) begin
          r_done <= r_grant;
          r_pkt  <= r_pkt + 16'd1;
        end else begin
          r_err  <= r_grant;
          r_errc <= w_errc_inc;
        end
      end
    end
  end

  assign src_rdreq      = w_rd ? r_grant : 3'b000;
  assign udp_tx_data    = ((r_state == S_SEND) && w_room) ? w_gdata : 8'h00;
  assign src_done       = r_done;
  assign src_err        = r_err;
  assign src_reject     = r_rej;
  assign udp_tx_request = r_req;
  assign udp_tx_length  = r_len;
  assign grant          = r_grant;
  assign busy           = (r_state != S_IDLE);
  assign pkt_count      = r_pkt;
  assign err_count      = r_errc;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: scoreboard bench with FWFT source and tx-stack models.
// Expected grants, bytes and pulses are queued at request time.
module tb_udp_tx_arbiter;

  logic        tx_clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        inhibit = 1'b0;
  logic [2:0]  src_req = 3'b000;
  logic [32:0] src_len = '0;
  logic [23:0] src_data;
  logic [2:0]  src_rdreq;
  logic [2:0]  src_done;
  logic [2:0]  src_err;
  logic [2:0]  src_reject;
  logic        udp_tx_request;
  logic [10:0] udp_tx_length;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_enable = 1'b0;
  logic        udp_tx_active = 1'b0;
  logic [2:0]  grant;
  logic        busy;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  always #5 tx_clock = ~tx_clock;

  udp_tx_arbiter dut (
    .tx_clock(tx_clock), .rst_n(rst_n), .inhibit(inhibit),
    .src_req(src_req), .src_len(src_len), .src_data(src_data),
    .src_rdreq(src_rdreq), .src_done(src_done), .src_err(src_err),
    .src_reject(src_reject), .udp_tx_request(udp_tx_request),
    .udp_tx_length(udp_tx_length), .udp_tx_data(udp_tx_data),
    .udp_tx_enable(udp_tx_enable), .udp_tx_active(udp_tx_active),
    .grant(grant), .busy(busy), .pkt_count(pkt_count),
    .err_count(err_count)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [7:0] seq [3];
  logic [7:0] pseq [3];
  int q_grant [$];
  logic [7:0] q_data [$];
  int q_evt [$];
  int en_dly = 0, n_act = 0, dly_cnt = 0, phase = 0, left = 0;
  bit stk_on = 1'b1;
  int exp_pkt = 0, exp_err = 0;
  int last_end = -1, req_rise = 0, err_cyc = 0;
  logic [2:0] prev_grant = 3'b000;
  logic prev_req = 1'b0;
  logic [2:0] rd = 3'b000;

  assign src_data = {8'h50 + seq[2], 8'hA0 + seq[1], 8'h10 + seq[0]};

  always @(posedge tx_clock) cyc <= cyc + 1;

  function automatic logic [7:0] base(int s);
    case (s)
      0: return 8'h10;
      1: return 8'hA0;
      default: return 8'h50;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge tx_clock);
    #2;
  endtask

  task automatic raise(int s, int len);
    src_len[11*s +: 11] = 11'(len);
    src_req[s] = 1'b1;
  endtask

  task automatic expect_pkt(int s, int len, int nact);
    int k;
    k = (len < nact) ? len : nact;
    q_grant.push_back(s);
    for (int j = 0; j < k; j++) begin
      q_data.push_back(base(s) + pseq[s]);
      pseq[s]++;
    end
    if (len == nact) begin
      q_evt.push_back(4 + s);
      exp_pkt++;
    end else begin
      q_evt.push_back(8 + s);
      exp_err++;
    end
  endtask

  task automatic expect_rej(int s);
    q_evt.push_back(12 + s);
    exp_err++;
  endtask

  task automatic note_evt(int t, int s);
    int e;
    e = t * 4 + s;
    if (q_evt.size() > 0) check("event", e, q_evt.pop_front());
    else check("event_x", e, 0);
    if (t != 3) last_end = cyc;
    if (t == 2) err_cyc = cyc;
    src_req[s] = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((q_grant.size() > 0 || q_data.size() > 0 || q_evt.size() > 0
            || busy) && n < budget) begin
      step(1);
      n++;
    end
    check("settle", n < budget, 1);
    check("pkt_count", pkt_count, exp_pkt);
    check("err_count", err_count, exp_err);
  endtask

  // monitor + source model on negedge, tx-stack model just after posedge
  initial forever begin
    @(negedge tx_clock);
    if (udp_tx_request && !prev_req) req_rise = cyc;
    prev_req = udp_tx_request;
    if (grant != 3'b000 && prev_grant == 3'b000) begin
      if (q_grant.size() > 0) check("grant", grant, 3'b001 << q_grant.pop_front());
      else check("grant_x", grant, 0);
      if (last_end >= 0) check("gap", (cyc - last_end) >= 13, 1);
    end
    prev_grant = grant;
    if (src_rdreq != 3'b000) begin
      check("rd_owner", src_rdreq, grant);
      if (q_data.size() > 0) check("data", udp_tx_data, q_data.pop_front());
      else check("data_x", src_rdreq, 0);
    end else if (udp_tx_active && grant != 3'b000) begin
      check("ovr_zero", udp_tx_data, 0);
    end
    for (int i = 0; i < 3; i++) begin
      if (src_done[i]) note_evt(1, i);
      if (src_err[i]) note_evt(2, i);
      if (src_reject[i]) note_evt(3, i);
    end
    rd = src_rdreq;
    @(posedge tx_clock);
    #1;
    for (int i = 0; i < 3; i++)
      if (rd[i]) seq[i]++;
    udp_tx_enable = 1'b0;
    if (phase == 0) begin
      if (stk_on && udp_tx_request) begin
        if (dly_cnt >= en_dly) begin
          udp_tx_enable = 1'b1;
          dly_cnt = 0;
          phase = 1;
        end else begin
          dly_cnt++;
        end
      end
    end else if (phase == 1) begin
      udp_tx_active = 1'b1;
      left = n_act - 1;
      phase = 2;
    end else begin
      if (left == 0) begin
        udp_tx_active = 1'b0;
        phase = 0;
      end else begin
        left--;
      end
    end
  end

  initial begin
    int t;
    int n;
    for (int i = 0; i < 3; i++) begin
      seq[i] = 8'd1;
      pseq[i] = 8'd1;
    end
    step(3);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_req", udp_tx_request, 0);
    check("rst_len", udp_tx_length, 0);
    check("rst_data", udp_tx_data, 0);
    check("rst_pulses", {src_rdreq, src_done, src_err, src_reject}, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_errc", err_count, 0);
    rst_n = 1'b1;
    step(2);

    en_dly = 3; n_act = 4;
    expect_pkt(1, 4, 4);
    raise(1, 4);
    t = cyc;
    wait_idle(200);
    check("req_lat", req_rise - t, 1);

    en_dly = 0; n_act = 2;
    expect_pkt(0, 2, 2); expect_pkt(2, 2, 2); expect_pkt(1, 2, 2);
    raise(0, 2); raise(1, 2); raise(2, 2);
    wait_idle(400);
    for (int r = 0; r < 2; r++) begin
      expect_pkt(2, 2, 2); expect_pkt(1, 2, 2);
      raise(1, 2); raise(2, 2);
      wait_idle(400);
    end

    inhibit = 1'b1;
    raise(1, 2); raise(2, 2);
    step(20);
    check("inh_grant", grant, 0);
    check("inh_busy", busy, 0);
    expect_pkt(0, 2, 2);
    raise(0, 2);
    wait_idle(200);
    expect_pkt(2, 2, 2); expect_pkt(1, 2, 2);
    inhibit = 1'b0;
    wait_idle(400);

    stk_on = 1'b0;
    expect_pkt(2, 5, 0);
    raise(2, 5);
    wait_idle(5000);
    check("tmo_lat", err_cyc - req_rise, 4095);
    check("tmo_req", udp_tx_request, 0);
    stk_on = 1'b1;

    expect_rej(0);
    raise(0, 0);
    wait_idle(50);
    expect_rej(1);
    raise(1, 1445);
    wait_idle(50);
    en_dly = 1; n_act = 8;
    expect_pkt(0, 10, 8);
    raise(0, 10);
    wait_idle(200);
    n_act = 5;
    expect_pkt(2, 3, 5);
    raise(2, 3);
    wait_idle(200);
    n_act = 2;
    expect_rej(0);
    expect_pkt(1, 2, 2);
    raise(0, 0); raise(1, 2);
    wait_idle(200);
    n_act = 1444;
    expect_pkt(0, 1444, 1444);
    raise(0, 1444);
    wait_idle(2000);

    en_dly = 0; n_act = 6;
    expect_pkt(1, 6, 6);
    raise(1, 6);
    n = 0;
    while (q_data.size() > 4 && n < 100) begin
      step(1);
      n++;
    end
    check("mid_send", n < 100, 1);
    rst_n = 1'b0;
    src_req = 3'b000;
    udp_tx_active = 1'b0;
    phase = 0;
    step(1);
    check("mrst_grant", grant, 0);
    check("mrst_busy", busy, 0);
    check("mrst_req", udp_tx_request, 0);
    check("mrst_len", udp_tx_length, 0);
    check("mrst_data", udp_tx_data, 0);
    check("mrst_pulses", {src_rdreq, src_done, src_err, src_reject}, 0);
    check("mrst_pkt", pkt_count, 0);
    check("mrst_errc", err_count, 0);
    rst_n = 1'b1;
    q_grant.delete(); q_data.delete(); q_evt.delete();
    pseq[1] = seq[1];
    exp_pkt = 0; exp_err = 0; last_end = -1;
    step(3);
    check("post_rst_busy", busy, 0);
    n_act = 2;
    expect_pkt(2, 2, 2);
    raise(2, 2);
    wait_idle(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
